// File: rtl/iter_divider.sv
// Restoring iterative divider: one conditional subtract per clock, signed or unsigned,
// with add/sub-style status flags (zf, sf, ovf) plus divide-by-zero.
module iter_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic             ovf,
   output logic             zf,
   output logic             sf
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dz_pend_q, dz_pend_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;
   logic             zf_q, zf_d;
   logic             sf_q, sf_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] most_neg;
   logic             is_dz, is_ovf, last_iter;
   logic [WIDTH:0]   rem_sh, trial;
   logic             q_bit;
   logic [WIDTH-1:0] q_fix, r_fix;

   assign most_neg  = {1'b1, {(WIDTH - 1){1'b0}}};
   assign a_neg     = signed_op & a[WIDTH-1];
   assign b_neg     = signed_op & b[WIDTH-1];
   assign a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
   assign b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
   assign is_dz     = (b == '0);
   assign is_ovf    = signed_op && (a == most_neg) && (b == '1);
   assign last_iter = (cnt_q == CntW'(WIDTH - 1));

   // Trial subtract in WIDTH+1 bits; the top bit is the sign of the difference.
   assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, div_q};
   assign q_bit  = ~trial[WIDTH];

   // Final result selection; the fast paths park the raw dividend in dvd_q.
   always_comb begin
      q_fix = q_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
      r_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
      if (dz_pend_q) begin
         q_fix = '1;
         r_fix = dvd_q;
      end else if (ovf_pend_q) begin
         q_fix = dvd_q;
         r_fix = '0;
      end
   end

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         div_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dz_pend_q   <= 1'b0;
         ovf_pend_q  <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         zf_q        <= 1'b0;
         sf_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         div_q       <= div_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         dz_pend_q   <= dz_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dz_q        <= dz_d;
         ovf_q       <= ovf_d;
         zf_q        <= zf_d;
         sf_q        <= sf_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (is_dz || is_ovf) ? StFix : StCalc;
            end
         end
         StCalc: begin
            if (last_iter) begin
               state_d = StFix;
            end
         end
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath and result register next values
   always_comb begin
      dvd_d       = dvd_q;
      div_d       = div_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      dz_pend_d   = dz_pend_q;
      ovf_pend_d  = ovf_pend_q;
      done_d      = (state_q == StFix);
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_d        = dz_q;
      ovf_d       = ovf_q;
      zf_d        = zf_q;
      sf_d        = sf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               dvd_d      = (is_dz || is_ovf) ? a : a_mag;
               div_d      = b_mag;
               rem_d      = '0;
               cnt_d      = '0;
               q_neg_d    = a_neg ^ b_neg;
               r_neg_d    = a_neg;
               dz_pend_d  = is_dz;
               ovf_pend_d = is_ovf && !is_dz;
            end
         end
         StCalc: begin
            rem_d = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q + CntW'(1);
         end
         StFix: begin
            quotient_d  = q_fix;
            remainder_d = r_fix;
            dz_d        = dz_pend_q;
            ovf_d       = ovf_pend_q;
            zf_d        = (q_fix == '0);
            sf_d        = q_fix[WIDTH-1];
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      busy      = (state_q != StIdle);
      done      = done_q;
      quotient  = quotient_q;
      remainder = remainder_q;
      dz        = dz_q;
      ovf       = ovf_q;
      zf        = zf_q;
      sf        = sf_q;
   end

endmodule
